// File: rtl/main_memory.sv
// Line-wide backing store shared by the instruction and data cache miss ports.
// Serves one fill or writeback at a time; ready pulses LATENCY+1 edges after acceptance.
module main_memory #(
    parameter int LATENCY     = 5,
    parameter int LINE_BITS   = 128,
    parameter int DEPTH_LINES = 4096
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_ready
);
    localparam int OFS = $clog2(LINE_BITS / 8);
    localparam int IDX = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           cnt;
    logic                 last_grant;
    logic                 lat_port;
    logic                 lat_we;
    logic [IDX-1:0]       lat_idx;
    logic [LINE_BITS-1:0] lat_wdata;
    logic                 accept;
    logic                 grant_d;
    logic                 done;

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    // Offset bits and the aliased upper address bits never select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:OFS+IDX], i_addr[OFS-1:0],
                                d_addr[31:OFS+IDX], d_addr[OFS-1:0]};

    // Port encoding: 0 = instruction, 1 = data. On a conflict the port that
    // did not win last time is granted.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        grant_d    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    accept     = 1'b1;
                    grant_d    = d_req && (!i_req || !last_grant);
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    done       = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // cnt starts at LATENCY so BUSY spans LATENCY+1 cycles and ready lands
    // in the cycle after edge accept+LATENCY+1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b0;
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state   <= next_state;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (accept) begin
                lat_port  <= grant_d;
                lat_we    <= grant_d & d_we;
                lat_idx   <= grant_d ? d_addr[OFS+IDX-1:OFS] : i_addr[OFS+IDX-1:OFS];
                lat_wdata <= d_wdata;
                cnt       <= 4'(LATENCY);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                if (lat_port) d_ready <= 1'b1;
                else          i_ready <= 1'b1;
                if (!lat_we) begin
                    if (lat_port) d_rdata <= mem[lat_idx];
                    else          i_rdata <= mem[lat_idx];
                end
            end
            if (state == RESP) begin
                last_grant <= lat_port;
            end
        end
    end

    // Storage is never reset; a reset during BUSY suppresses done, so an
    // aborted writeback leaves the line untouched.
    always_ff @(posedge clock) begin
        if (done && lat_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end
endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: drivers queue expected responses, a
// negedge monitor pops and compares them whenever a ready pulse appears.
module tb_main_memory;
    localparam int LATENCY = 5;
    localparam int EXP_LAT = LATENCY + 3;

    localparam logic [127:0] LINE3  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DEAD   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    localparam logic [127:0] LINE2  = 128'h2222_3333_4444_5555_6666_7777_8888_9999;
    localparam logic [127:0] FIVE   = 128'h5;
    localparam logic [127:0] JUNK   = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    localparam logic [127:0] ALIAS  = 128'hA11A_5A11_A5A1_1A5A_0BAD_CAFE_1234_5678;
    localparam logic [127:0] LINE9  = 128'h9999_0000_9999_0000_1111_2222_3333_4444;

    logic         clock;
    logic         reset;
    logic         i_req;
    logic [31:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_ready;
    logic         d_req;
    logic         d_we;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_ready;

    typedef struct packed {
        logic         port;
        logic [127:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] exp_i_rdata;
    logic [127:0] exp_d_rdata;
    int           vectors;
    int           miscompares;

    main_memory #(.LATENCY(LATENCY), .LINE_BITS(128), .DEPTH_LINES(4096)) dut (
        .clock   (clock),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ready (d_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input logic port, input logic [127:0] rdata);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_ready port=%0d rdata=%h required no response", port, rdata);
        end else begin
            e = exp_q.pop_front();
            if (e.port != port) begin
                miscompares++;
                $display("[TB] FAIL grant_order served port=%0d required port=%0d", port, e.port);
            end else if (rdata !== e.data) begin
                miscompares++;
                $display("[TB] FAIL rdata port=%0d got=%h required=%h", port, rdata, e.data);
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (i_ready) check_output(1'b0, i_rdata);
            if (d_ready) check_output(1'b1, d_rdata);
        end
    end

    task automatic expect_fill(input logic port, input logic [127:0] data);
        if (port) exp_d_rdata = data;
        else      exp_i_rdata = data;
        exp_q.push_back('{port: port, data: data});
    endtask

    task automatic expect_write();
        exp_q.push_back('{port: 1'b1, data: exp_d_rdata});
    endtask

    task automatic check_value(input string name, input logic [127:0] got, input logic [127:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic apply_stimulus(input logic port, input logic we, input logic [31:0] addr,
                                  input logic [127:0] wdata, input int exp_lat);
        int  n;
        bit  got;
        @(posedge clock);
        #1;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(negedge clock);
            n++;
            if (port ? d_ready : i_ready) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_timeout port=%0d addr=%h waited=%0d cycles", port, addr, n);
        end else if (exp_lat != 0) begin
            vectors++;
            if (n != exp_lat) begin
                miscompares++;
                $display("[TB] FAIL latency port=%0d got=%0d required=%0d", port, n, exp_lat);
            end
        end
        @(posedge clock);
        #1;
        if (port) begin
            d_req = 1'b0; d_we = 1'b0;
        end else begin
            i_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        vectors     = 0;
        miscompares = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        #2;
        check_value("reset_i_ready", 128'(i_ready), '0);
        check_value("reset_d_ready", 128'(d_ready), '0);
        check_value("reset_i_rdata", i_rdata, '0);
        check_value("reset_d_rdata", d_rdata, '0);
        check_value("reset_cnt", 128'(dut.cnt), '0);
        @(negedge clock);
        reset = 1'b0;

        // Preload through the data port, then the instruction fill from the plan.
        expect_write();
        apply_stimulus(1'b1, 1'b1, 32'h30, LINE3, EXP_LAT);
        expect_fill(1'b0, LINE3);
        apply_stimulus(1'b0, 1'b0, 32'h30, '0, EXP_LAT);

        // Writeback leaves d_rdata alone; the following fill sees the new line.
        expect_write();
        apply_stimulus(1'b1, 1'b1, 32'h1000, DEAD, EXP_LAT);
        expect_fill(1'b1, DEAD);
        apply_stimulus(1'b1, 1'b0, 32'h1000, '0, EXP_LAT);

        expect_write();
        apply_stimulus(1'b1, 1'b1, 32'h20, LINE2, EXP_LAT);
        expect_write();
        apply_stimulus(1'b1, 1'b1, 32'h70, FIVE, EXP_LAT);
        expect_write();
        apply_stimulus(1'b1, 1'b1, 32'h90, LINE9, EXP_LAT);

        // Asynchronous reset between clock edges with non-zero rdata outstanding.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_value("async_i_rdata", i_rdata, '0);
        check_value("async_d_rdata", d_rdata, '0);
        check_value("async_state_idle", 128'(int'(dut.state)), '0);
        check_value("async_cnt", 128'(dut.cnt), '0);
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        @(negedge clock);
        reset = 1'b0;

        // Three simultaneous rounds: d wins the first conflict after reset,
        // and strict alternation keeps d first in each later round.
        expect_fill(1'b1, DEAD);
        expect_fill(1'b0, LINE2);
        fork
            apply_stimulus(1'b1, 1'b0, 32'h1000, '0, EXP_LAT);
            apply_stimulus(1'b0, 1'b0, 32'h20, '0, 0);
        join
        expect_fill(1'b1, FIVE);
        expect_fill(1'b0, LINE3);
        fork
            apply_stimulus(1'b1, 1'b0, 32'h70, '0, 0);
            apply_stimulus(1'b0, 1'b0, 32'h30, '0, 0);
        join
        expect_fill(1'b1, LINE9);
        expect_fill(1'b0, DEAD);
        fork
            apply_stimulus(1'b1, 1'b0, 32'h90, '0, 0);
            apply_stimulus(1'b0, 1'b0, 32'h1000, '0, 0);
        join

        // Abort a writeback to line 7 two cycles after it is accepted.
        @(posedge clock);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h70; d_wdata = JUNK;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        d_req = 1'b0;
        d_we  = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (d_ready) pulses++;
        end
        check_value("abort_no_ready", 128'(pulses), '0);
        expect_fill(1'b1, FIVE);
        apply_stimulus(1'b1, 1'b0, 32'h70, '0, EXP_LAT);

        // Upper address bits alias onto the same line.
        expect_write();
        apply_stimulus(1'b1, 1'b1, 32'h0001_0010, ALIAS, EXP_LAT);
        expect_fill(1'b1, ALIAS);
        apply_stimulus(1'b1, 1'b0, 32'h0000_0010, '0, EXP_LAT);
        expect_fill(1'b0, ALIAS);
        apply_stimulus(1'b0, 1'b0, 32'h0000_001C, '0, EXP_LAT);

        repeat (4) @(negedge clock);
        check_value("scoreboard_drained", 128'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
